// File: rtl/addsub_seq.sv
// Word-serial two's complement adder/subtractor.
// A single n-bit addsub is reused once per word, least significant word first,
// with the carry/borrow chained through a register between words.

`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

// n-bit add/subtract slice; in subtract mode b and cin are inverted so that
// cin/cout both carry borrow semantics (1 = borrow).
module addsub #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic [n-1:0] s,
  output logic         cout,
  output logic         overflow
);

  logic [n-1:0] bx;
  logic         ci;
  logic         co;

  // Ripple add of a and the conditionally inverted b, plus signed overflow.
  always_comb begin
    bx       = sub ? ~b : b;
    ci       = sub ? ~cin : cin;
    {co, s}  = {1'b0, a} + {1'b0, bx} + {{n{1'b0}}, ci};
    cout     = sub ? ~co : co;
    overflow = (a[n-1] == bx[n-1]) && (s[n-1] != a[n-1]);
  end

endmodule

module addsub_seq #(
  parameter int n     = `DEFAULT_WIDTH,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sub,
  input  logic [n*WORDS-1:0] a,
  input  logic [n*WORDS-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [n*WORDS-1:0] sum,
  output logic               cout,
  output logic               overflow,
  output logic               zero
);

  localparam int            KW   = $clog2(WORDS + 1);
  localparam logic [KW-1:0] LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  logic [KW-1:0]      k;
  logic [n*WORDS-1:0] a_q;
  logic [n*WORDS-1:0] b_q;
  logic               sub_q;
  logic               carry_q;

  logic [n-1:0]       a_w;
  logic [n-1:0]       b_w;
  logic               cin_w;
  logic [n-1:0]       s_w;
  logic               cout_w;
  logic               ovf_w;

  // Select word k of the captured operands for the shared slice.
  always_comb begin
    a_w = '0;
    b_w = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (k == KW'(i)) begin
        a_w = a_q[i*n +: n];
        b_w = b_q[i*n +: n];
      end
    end
    cin_w = (k == '0) ? 1'b0 : carry_q;
  end

  addsub #(.n(n)) u_addsub (
    .a        (a_w),
    .b        (b_w),
    .sub      (sub_q),
    .cin      (cin_w),
    .s        (s_w),
    .cout     (cout_w),
    .overflow (ovf_w)
  );

  // Control FSM: capture on start, write one word per RUN cycle, pulse DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            k     <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < WORDS; i++) begin
            if (k == KW'(i)) sum[i*n +: n] <= s_w;
          end
          carry_q <= cout_w;
          k       <= k + 1'b1;
          if (k == LAST) begin
            cout     <= cout_w;
            overflow <= ovf_w;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign zero = (sum == '0);

endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench for addsub_seq (n=8, WORDS=4): the driver pushes the
// expected result and its done cycle; the monitor pops on every done pulse.
module tb_addsub_seq;

  localparam int N = 8;
  localparam int W = 4;
  localparam int B = N * W;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sub;
  logic [B-1:0] a;
  logic [B-1:0] b;
  logic         busy;
  logic         done;
  logic [B-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         zero;

  addsub_seq #(.n(N), .WORDS(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [B-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: whole-operand arithmetic on B-bit two's complement values.
  function automatic exp_t model(input logic [B-1:0] x, input logic [B-1:0] y, input logic s);
    exp_t         e;
    logic [B:0]   full;
    if (!s) begin
      full   = {1'b0, x} + {1'b0, y};
      e.sum  = full[B-1:0];
      e.cout = full[B];
      e.ovf  = (x[B-1] == y[B-1]) && (e.sum[B-1] != x[B-1]);
    end else begin
      e.sum  = x - y;
      e.cout = (x < y);
      e.ovf  = (x[B-1] != y[B-1]) && (e.sum[B-1] != x[B-1]);
    end
    e.zero = (e.sum == '0);
    e.cyc  = 0;
    return e;
  endfunction

  // Drive start at a negedge and record the expected outcome.
  task automatic issue(input logic [B-1:0] x, input logic [B-1:0] y, input logic s);
    exp_t e;
    a     = x;
    b     = y;
    sub   = s;
    start = 1'b1;
    e     = model(x, y, s);
    e.cyc = cyc + 5;
    q.push_back(e);
    last  = e;
  endtask

  // One isolated operation, ending on the negedge where done is visible.
  task automatic do_op(input logic [B-1:0] x, input logic [B-1:0] y, input logic s);
    @(negedge clk);
    issue(x, y, s);
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", {63'd0, busy}, 64'd1);
    repeat (4) @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", 64'(sum), 64'(e.sum));
        chk("cout", {63'd0, cout}, {63'd0, e.cout});
        chk("overflow", {63'd0, overflow}, {63'd0, e.ovf});
        chk("zero", {63'd0, zero}, {63'd0, e.zero});
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed vectors.
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    do_op(32'h0000_0000, 32'h0000_0001, 1'b1);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1);

    // Results hold in IDLE.
    repeat (3) @(negedge clk);
    chk("hold_sum", 64'(sum), 64'(last.sum));
    chk("hold_zero", {63'd0, zero}, {63'd0, last.zero});

    // Start during RUN is ignored.
    @(negedge clk);
    issue(32'h1234_5678, 32'h0101_0101, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a     = 32'hDEAD_BEEF;
    b     = 32'hCAFE_F00D;
    sub   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("ignored_start_drained", 64'(q.size()), 64'd0);

    // Reset during RUN aborts; start coincident with release is accepted.
    @(negedge clk);
    issue(32'h0F0F_0F0F, 32'h7070_7070, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    q.delete();
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_cout", {63'd0, cout}, 64'd0);
    chk("abort_ovf", {63'd0, overflow}, 64'd0);
    chk("abort_zero", {63'd0, zero}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    issue(32'h0000_0005, 32'h0000_0007, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);

    // Back-to-back with start held high: done every 5 cycles.
    @(negedge clk);
    issue(32'h89AB_CDEF, 32'h7654_3210, 1'b0);
    for (int i = 0; i < 2; i++) begin
      repeat (5) @(negedge clk);
      issue(32'h89AB_CDEF, 32'h7654_3210, 1'b0);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);

    // Randomized operations with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      logic [B-1:0] x;
      logic [B-1:0] y;
      x = $urandom();
      y = $urandom();
      if (i % 8 == 0) y = x;
      do_op(x, y, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
